mem_port_arbiter: RTL and testbench

Shares one single-ported, variable-latency unified memory between the IF stage (instruction fetch) and the MEM stage (lw/sw) of the 5-stage RISC-V pipeline. Data accesses have priority. The block generates StallFetch/StallMem, which the hazard unit ORs into its StallF/StallD/StallE/StallM/FlushW logic. It holds a one-entry instruction buffer, and a watchdog flags memory that never answers.

---
 rtl/mem_port_arbiter_pkg.sv | 16 +
 rtl/mem_port_arbiter_watchdog.sv | 38 +++
 rtl/mem_port_arbiter.sv | 141 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the IF/MEM unified-memory port arbiter.
package mem_port_arbiter_pkg;

    localparam int unsigned XLEN = 32;

    // addi x0,x0,0 -- handed to IF when a fetch times out
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h00000013;

    // Arbiter FSM encoding (kept as plain constants for legacy tools)
    typedef logic [1:0] arbState_t;
    localparam arbState_t StIdle  = 2'd0;
    localparam arbState_t StData  = 2'd1;
    localparam arbState_t StDDone = 2'd2;
    localparam arbState_t StInstr = 2'd3;

endpackage

// File: rtl/mem_port_arbiter_watchdog.sv
// Wait-cycle counter for an outstanding memory request; forces completion
// after TIMEOUT unanswered cycles and raises a sticky bus error.
module arb_watchdog #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic active,
    input  logic memReady,
    output logic expire,
    output logic busError
);

    localparam int unsigned CntW = $clog2(TIMEOUT + 1);

    logic [CntW-1:0] wdog;

    // MemReady wins over a same-cycle expiry, so a late answer is never lost
    assign expire = active && !memReady && (wdog == CntW'(TIMEOUT));

    // Count unanswered cycles; restart whenever the request finishes
    always_ff @(posedge clk) begin
        if (reset) begin
            wdog     <= '0;
            busError <= 1'b0;
        end else begin
            if (!active || memReady || expire) begin
                wdog <= '0;
            end else begin
                wdog <= wdog + CntW'(1);
            end
            if (expire) begin
                busError <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-ported, variable-latency memory between instruction
// fetch and the MEM stage. Data accesses win ties; fetched words land in a
// one-entry buffer that IF consumes when it is not held.
module mem_port_arbiter #(
    parameter int unsigned TIMEOUT   = 255,
    parameter logic [31:0] NOP_INSTR = mem_port_arbiter_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        InstrReqF,
    input  logic [31:0] PCF,
    input  logic        FlushF,
    input  logic        HoldF,
    input  logic        DataReqM,
    input  logic        DataWEM,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    input  logic [3:0]  ByteEnM,
    output logic        MemReq,
    output logic        MemWE,
    output logic [31:0] MemAddr,
    output logic [31:0] MemWData,
    output logic [3:0]  MemBE,
    input  logic [31:0] MemRData,
    input  logic        MemReady,
    output logic [31:0] InstrF,
    output logic        InstrValidF,
    output logic [31:0] ReadDataM,
    output logic        DataDoneM,
    output logic        StallFetch,
    output logic        StallMem,
    output logic        BusError
);
    import mem_port_arbiter_pkg::*;

    arbState_t state;
    arbState_t stateNext;
    logic      ibufValid;
    logic      discard;
    logic      busy;
    logic      wdogExpire;
    logic      memDone;

    assign busy        = (state == StData) || (state == StInstr);
    assign memDone     = busy && (MemReady || wdogExpire);
    assign DataDoneM   = (state == StDDone);
    assign InstrValidF = ibufValid;
    assign StallFetch  = InstrReqF & ~ibufValid;
    assign StallMem    = DataReqM & ~DataDoneM;

    arb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) uWatchdog (
        .clk      (clk),
        .reset    (reset),
        .active   (busy),
        .memReady (MemReady),
        .expire   (wdogExpire),
        .busError (BusError)
    );

    // Next-state decode; a new fetch waits until the buffer has drained
    always_comb begin
        stateNext = state;
        case (state)
            StIdle: begin
                if (DataReqM) begin
                    stateNext = StData;
                end else if (InstrReqF && !ibufValid && !FlushF) begin
                    stateNext = StInstr;
                end
            end
            StData:  if (memDone) stateNext = StDDone;
            StDDone: stateNext = StIdle;
            StInstr: if (memDone) stateNext = StIdle;
            default: stateNext = StIdle;
        endcase
    end

    // Request registers, captured read data and the instruction buffer
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= StIdle;
            MemReq    <= 1'b0;
            MemWE     <= 1'b0;
            MemAddr   <= '0;
            MemWData  <= '0;
            MemBE     <= '0;
            ReadDataM <= '0;
            InstrF    <= '0;
            ibufValid <= 1'b0;
            discard   <= 1'b0;
        end else begin
            state <= stateNext;

            // Redirect or consumption empties the buffer
            if (FlushF || (ibufValid && !HoldF && !StallMem)) begin
                ibufValid <= 1'b0;
            end

            case (state)
                StIdle: begin
                    if (stateNext == StData) begin
                        MemReq   <= 1'b1;
                        MemWE    <= DataWEM;
                        MemAddr  <= ALUResultM;
                        MemWData <= WriteDataM;
                        MemBE    <= DataWEM ? ByteEnM : 4'hF;
                    end else if (stateNext == StInstr) begin
                        MemReq  <= 1'b1;
                        MemWE   <= 1'b0;
                        MemAddr <= PCF;
                        MemBE   <= 4'hF;
                    end
                end
                StData: begin
                    if (memDone) begin
                        MemReq    <= 1'b0;
                        ReadDataM <= MemReady ? MemRData : '0;
                    end
                end
                StInstr: begin
                    if (memDone) begin
                        MemReq  <= 1'b0;
                        discard <= 1'b0;
                        // A word fetched for a squashed PC is dropped
                        if (!discard && !FlushF) begin
                            InstrF    <= MemReady ? MemRData : NOP_INSTR;
                            ibufValid <= 1'b1;
                        end
                    end else if (FlushF) begin
                        // Never abort an issued request; just forget its result
                        discard <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    localparam int          TOUT = 255;
    localparam logic [31:0] NOP  = 32'h00000013;

    logic        clk = 1'b0;
    logic        reset;
    logic        InstrReqF, FlushF, HoldF, DataReqM, DataWEM;
    logic [31:0] PCF, ALUResultM, WriteDataM, MemRData;
    logic [3:0]  ByteEnM;
    logic        MemReady;
    logic        MemReq, MemWE, InstrValidF, DataDoneM, StallFetch, StallMem, BusError;
    logic [31:0] MemAddr, MemWData, InstrF, ReadDataM;
    logic [3:0]  MemBE;

    int checks = 0;
    int errors = 0;
    bit chkEn  = 1'b0;
    int lat    = 0;   // cycles of MemReq before MemReady; negative = never answer
    int age    = 0;

    mem_port_arbiter dut (
        .clk         (clk),
        .reset       (reset),
        .InstrReqF   (InstrReqF),
        .PCF         (PCF),
        .FlushF      (FlushF),
        .HoldF       (HoldF),
        .DataReqM    (DataReqM),
        .DataWEM     (DataWEM),
        .ALUResultM  (ALUResultM),
        .WriteDataM  (WriteDataM),
        .ByteEnM     (ByteEnM),
        .MemReq      (MemReq),
        .MemWE       (MemWE),
        .MemAddr     (MemAddr),
        .MemWData    (MemWData),
        .MemBE       (MemBE),
        .MemRData    (MemRData),
        .MemReady    (MemReady),
        .InstrF      (InstrF),
        .InstrValidF (InstrValidF),
        .ReadDataM   (ReadDataM),
        .DataDoneM   (DataDoneM),
        .StallFetch  (StallFetch),
        .StallMem    (StallMem),
        .BusError    (BusError)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Advance one clock; the memory responder reacts to the request it sees
    task automatic tick();
        @(posedge clk);
        #1;
        MemReady = (MemReq === 1'b1) && (lat >= 0) && (age == lat);
        if (MemReq === 1'b1) age++;
        else age = 0;
    endtask

    // Transaction-level reference: kind 0 none, 1 load/store, 2 fetch, 3 data-done pulse
    int          kind = 0;
    int          waited = 0;
    bit          mWE = 0, mIbuf = 0, mDrop = 0, mBusErr = 0;
    logic [31:0] mAddr = 0, mWData = 0, mRData = 0, mInstr = 0;
    logic [3:0]  mBE = 0;

    always @(negedge clk) begin
        bit consumed, nextIbuf, tout;
        if (chkEn) begin
            check("MemReq",      MemReq,      32'(kind == 1 || kind == 2));
            check("MemWE",       MemWE,       32'(mWE));
            check("MemAddr",     MemAddr,     mAddr);
            check("MemWData",    MemWData,    mWData);
            check("MemBE",       MemBE,       32'(mBE));
            check("ReadDataM",   ReadDataM,   mRData);
            check("InstrF",      InstrF,      mInstr);
            check("InstrValidF", InstrValidF, 32'(mIbuf));
            check("DataDoneM",   DataDoneM,   32'(kind == 3));
            check("StallFetch",  StallFetch,  32'(InstrReqF && !mIbuf));
            check("StallMem",    StallMem,    32'(DataReqM && kind != 3));
            check("BusError",    BusError,    32'(mBusErr));
        end
        if (reset) begin
            kind = 0; waited = 0; mWE = 0; mIbuf = 0; mDrop = 0; mBusErr = 0;
            mAddr = 0; mWData = 0; mRData = 0; mInstr = 0; mBE = 0;
        end else begin
            consumed = mIbuf && !HoldF && !(DataReqM && kind != 3) && !FlushF;
            nextIbuf = mIbuf && !FlushF && !consumed;
            case (kind)
                0: begin
                    if (DataReqM) begin
                        kind = 1; waited = 0; mWE = DataWEM; mAddr = ALUResultM;
                        mWData = WriteDataM; mBE = DataWEM ? ByteEnM : 4'hF;
                    end else if (InstrReqF && !mIbuf && !FlushF) begin
                        kind = 2; waited = 0; mWE = 0; mAddr = PCF; mBE = 4'hF;
                    end
                end
                3: kind = 0;
                default: begin
                    tout = !MemReady && (waited == TOUT);
                    if (MemReady || tout) begin
                        if (tout) mBusErr = 1;
                        if (kind == 1) begin
                            mRData = tout ? 32'h0 : MemRData;
                            kind = 3;
                        end else begin
                            if (!mDrop && !FlushF) begin
                                mInstr = tout ? NOP : MemRData;
                                nextIbuf = 1;
                            end
                            mDrop = 0;
                            kind = 0;
                        end
                    end else begin
                        waited++;
                        if (kind == 2 && FlushF) mDrop = 1;
                    end
                end
            endcase
            mIbuf = nextIbuf;
        end
    end

    initial begin
        int k;
        reset = 1; InstrReqF = 0; FlushF = 0; HoldF = 0; DataReqM = 0; DataWEM = 0;
        PCF = 0; ALUResultM = 0; WriteDataM = 0; ByteEnM = 0; MemRData = 0; MemReady = 0;
        tick(); tick();
        chkEn = 1;
        check("rst_MemReq", MemReq, 0);
        check("rst_BusError", BusError, 0);
        check("rst_InstrValidF", InstrValidF, 0);
        check("rst_DataDoneM", DataDoneM, 0);
        reset = 0;

        // Load answered in the first request cycle
        lat = 0; MemRData = 32'hDEADBEEF;
        DataReqM = 1; DataWEM = 0; ALUResultM = 32'h100;
        tick();
        check("ld_MemAddr", MemAddr, 32'h100);
        check("ld_MemWE", MemWE, 0);
        check("ld_StallMem_wait", StallMem, 1);
        tick();
        check("ld_DataDoneM", DataDoneM, 1);
        check("ld_ReadDataM", ReadDataM, 32'hDEADBEEF);
        check("ld_StallMem_done", StallMem, 0);
        DataReqM = 0;
        tick();
        check("ld_pulse_end", DataDoneM, 0);

        // Same-cycle tie: store first, then fetch
        InstrReqF = 1; PCF = 32'h40;
        DataReqM = 1; DataWEM = 1; ALUResultM = 32'h200; WriteDataM = 32'h55; ByteEnM = 4'b0001;
        tick();
        check("tie_MemWE", MemWE, 1);
        check("tie_MemBE", MemBE, 4'b0001);
        check("tie_MemAddr", MemAddr, 32'h200);
        tick();
        DataReqM = 0; DataWEM = 0; MemRData = 32'h00100093;
        tick(); tick();
        check("tie_fetch_addr", MemAddr, 32'h40);
        check("tie_fetch_BE", MemBE, 4'hF);
        tick();
        check("tie_InstrF", InstrF, 32'h00100093);
        check("tie_InstrValidF", InstrValidF, 1);
        InstrReqF = 0;
        tick();
        check("tie_consumed", InstrValidF, 0);

        // Fetch squashed by a redirect while waiting
        lat = 2; MemRData = 32'h00500093; InstrReqF = 1; PCF = 32'h40;
        tick();
        FlushF = 1; PCF = 32'h80;
        tick();
        FlushF = 0;
        tick(); tick();
        check("flush_dropped", InstrValidF, 0);
        tick();
        check("flush_refetch_addr", MemAddr, 32'h80);
        MemRData = 32'hABCD0113; HoldF = 1;
        k = 0;
        while (!InstrValidF && k < 20) begin tick(); k++; end
        check("flush_refetch_word", InstrF, 32'hABCD0113);

        // Load under HoldF keeps the buffered instruction
        lat = 1; MemRData = 32'h11112222; DataReqM = 1; ALUResultM = 32'h300;
        tick(); tick(); tick();
        check("hold_DataDoneM", DataDoneM, 1);
        check("hold_ReadDataM", ReadDataM, 32'h11112222);
        check("hold_InstrF", InstrF, 32'hABCD0113);
        check("hold_InstrValidF", InstrValidF, 1);
        DataReqM = 0; HoldF = 0; InstrReqF = 0;
        tick();
        check("hold_released", InstrValidF, 0);

        // Load that memory never answers
        lat = -1; MemRData = 32'hFFFFFFFF; DataReqM = 1; ALUResultM = 32'h400;
        tick();
        k = 0;
        while (!DataDoneM && k < 400) begin tick(); k++; end
        check("tout_ld_cycles", k, 256);
        check("tout_ld_ReadDataM", ReadDataM, 0);
        check("tout_ld_BusError", BusError, 1);
        DataReqM = 0; InstrReqF = 1; PCF = 32'h500;
        tick();
        k = 0;
        while (!InstrValidF && k < 400) begin tick(); k++; end
        check("tout_fetch_InstrF", InstrF, 32'h00000013);
        check("tout_sticky_BusError", BusError, 1);
        InstrReqF = 0;
        tick();

        // Reset while a load is waiting
        DataReqM = 1; ALUResultM = 32'h600;
        tick(); tick(); tick();
        check("rstmid_req_before", MemReq, 1);
        reset = 1; DataReqM = 0;
        tick();
        check("rstmid_MemReq", MemReq, 0);
        check("rstmid_DataDoneM", DataDoneM, 0);
        check("rstmid_BusError", BusError, 0);
        check("rstmid_MemAddr", MemAddr, 0);
        reset = 0;
        tick(); tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
